// File: rtl/shake_pkg.sv
// Shared constants, types and helpers for the SHAKE absorb stage.
// Rates are in bits; padding bytes follow the SHAKE domain-separation rule.
package shake_pkg;

    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    localparam logic [7:0] PAD_DOMAIN = 8'h1F;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        ABSORB,
        PAD,
        HOLD
    } absorb_state_t;

    function automatic int rate_bits(input shake_mode_t mode);
        return (mode == SHAKE256) ? RATE_SHAKE256 : RATE_SHAKE128;
    endfunction

endpackage

// File: rtl/shake_pad_word.sv
// Masks a word to its first keep bytes, optionally drops the 0x1F domain byte
// right after the kept bytes, and optionally ORs 0x80 into the top byte.
module shake_pad_word
    import shake_pkg::*;
#(
    parameter  int W  = 64,
    localparam int KW = $clog2(W/8) + 1
) (
    input  logic [W-1:0]  word_in,
    input  logic [KW-1:0] keep,
    input  logic          dom_en,
    input  logic          end_en,
    output logic [W-1:0]  word_out
);

    localparam int WB = W / 8;

    always_comb begin
        word_out = '0;
        for (int b = 0; b < WB; b++) begin
            if (b < int'(keep)) begin
                word_out[b*8 +: 8] = word_in[b*8 +: 8];
            end else if (dom_en && (b == int'(keep))) begin
                word_out[b*8 +: 8] = PAD_DOMAIN;
            end
        end
        // Domain byte and end byte may share the top byte, giving 0x9F.
        if (end_en) begin
            word_out[W-1 -: 8] = word_out[W-1 -: 8] | PAD_END;
        end
    end

endmodule

// File: rtl/shake_absorb_buffer.sv
// Assembles a W-bit message word stream into rate-sized SHAKE blocks with
// hardware padding, handing each block out over a valid/ready interface.
module shake_absorb_buffer
    import shake_pkg::*;
#(
    parameter  int W        = 64,
    parameter  int RATE_MAX = 1344,
    localparam int KW       = $clog2(W/8) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic                in_last,
    input  logic [KW-1:0]       in_keep,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic [RATE_MAX-1:0] blk_data,
    output logic                blk_last,
    output logic                blk_mode
);

    localparam int WB     = W / 8;
    localparam int NW_MAX = RATE_MAX / W;
    localparam int CW     = $clog2(NW_MAX + 1);
    localparam logic [KW-1:0] KEEP_FULL = KW'(WB);

    absorb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          last_q, last_d;
    logic          mode_q, mode_d;
    logic [NW_MAX-1:0][W-1:0] buf_q, buf_d, pad_out;

    shake_mode_t   cur_mode;
    logic [CW-1:0] top_idx;
    logic [KW-1:0] keep_eff;
    logic          accept;
    logic          full_word;
    logic          at_top;
    logic          boundary;

    // The rate is taken from mode_in only while the first word is in flight.
    always_comb begin
        cur_mode  = (state_q == IDLE) ? shake_mode_t'(mode_in) : shake_mode_t'(mode_q);
        top_idx   = CW'(rate_bits(cur_mode) / W - 1);
        if (!in_last || (in_keep > KEEP_FULL)) begin
            keep_eff = KEEP_FULL;
        end else begin
            keep_eff = in_keep;
        end
        full_word = (keep_eff == KEEP_FULL);
        at_top    = (cnt_q == top_idx);
        boundary  = in_last && full_word && at_top;
    end

    assign in_ready  = rst && ((state_q == IDLE) || (state_q == ABSORB));
    assign accept    = in_valid && in_ready;
    assign blk_valid = (state_q == HOLD);
    assign blk_data  = buf_q;
    assign blk_last  = last_q;
    assign blk_mode  = mode_q;

    // Each slot computes what an accepted word (or the PAD state) contributes.
    for (genvar gi = 0; gi < NW_MAX; gi++) begin : g_slot
        logic          slot_hit;
        logic          slot_next;
        logic          slot_top;
        logic [W-1:0]  w_in;
        logic [KW-1:0] k_in;
        logic          d_en;
        logic          e_en;

        assign slot_hit  = (cnt_q == CW'(gi));
        assign slot_next = ((cnt_q + CW'(1)) == CW'(gi));
        assign slot_top  = (top_idx == CW'(gi));

        always_comb begin
            w_in = '0;
            k_in = '0;
            d_en = 1'b0;
            e_en = 1'b0;
            if (state_q == PAD) begin
                d_en = (gi == 0);
                e_en = slot_top;
            end else begin
                if (slot_hit) begin
                    w_in = in_data;
                    k_in = keep_eff;
                    d_en = in_last && !full_word;
                end
                // A full last word below the top spills the domain byte forward.
                if (slot_next && in_last && full_word && !at_top) begin
                    d_en = 1'b1;
                end
                e_en = slot_top && in_last && !boundary;
            end
        end

        shake_pad_word #(.W(W)) u_pad (
            .word_in  (w_in),
            .keep     (k_in),
            .dom_en   (d_en),
            .end_en   (e_en),
            .word_out (pad_out[gi])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        last_d  = last_q;
        mode_d  = mode_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE, ABSORB: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        mode_d = mode_in;
                    end
                    buf_d = buf_q | pad_out;
                    cnt_d = cnt_q + CW'(1);
                    if (in_last) begin
                        state_d = HOLD;
                        last_d  = !boundary;
                        pend_d  = boundary;
                    end else if (at_top) begin
                        state_d = HOLD;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end
            PAD: begin
                buf_d   = pad_out;
                state_d = HOLD;
                last_d  = 1'b1;
                pend_d  = 1'b0;
            end
            HOLD: begin
                if (blk_ready) begin
                    buf_d  = '0;
                    cnt_d  = '0;
                    last_d = 1'b0;
                    pend_d = 1'b0;
                    if (pend_q) begin
                        state_d = PAD;
                    end else if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            mode_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_shake_absorb_buffer.sv
// Randomised bench for shake_absorb_buffer (W=64 and W=32 instances) checked
// against a byte-level SHAKE padding model.
module tb_shake_absorb_buffer;

    localparam int RM = 1344;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          mode_a = 0, in_valid_a = 0, in_last_a = 0, blk_ready_a = 0;
    logic [63:0]   in_data_a = '0;
    logic [3:0]    in_keep_a = '0;
    logic          in_ready_a, blk_valid_a, blk_last_a, blk_mode_a;
    logic [RM-1:0] blk_data_a;

    logic          mode_b = 0, in_valid_b = 0, in_last_b = 0, blk_ready_b = 0;
    logic [31:0]   in_data_b = '0;
    logic [2:0]    in_keep_b = '0;
    logic          in_ready_b, blk_valid_b, blk_last_b, blk_mode_b;
    logic [RM-1:0] blk_data_b;

    shake_absorb_buffer #(.W(64), .RATE_MAX(RM)) dut_a (
        .clk(clk), .rst(rst), .mode_in(mode_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .in_last(in_last_a), .in_keep(in_keep_a), .blk_valid(blk_valid_a),
        .blk_ready(blk_ready_a), .blk_data(blk_data_a), .blk_last(blk_last_a), .blk_mode(blk_mode_a)
    );

    shake_absorb_buffer #(.W(32), .RATE_MAX(RM)) dut_b (
        .clk(clk), .rst(rst), .mode_in(mode_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .in_last(in_last_b), .in_keep(in_keep_b), .blk_valid(blk_valid_b),
        .blk_ready(blk_ready_b), .blk_data(blk_data_b), .blk_last(blk_last_b), .blk_mode(blk_mode_b)
    );

    // Reference: append 0x1F after the message, zero-fill to a whole number of
    // rate blocks (always at least one pad byte), and OR 0x80 into the final byte.
    function automatic void model(input bit mode, input logic [7:0] msg[$], output logic [RM-1:0] exp[$]);
        int r;
        int len;
        int nb;
        logic [7:0] p[$];
        logic [RM-1:0] blk;
        r   = mode ? 136 : 168;
        len = msg.size();
        nb  = len / r + 1;
        exp.delete();
        p = msg;
        while (p.size() < nb * r) p.push_back(8'h00);
        p[len]        = p[len] | 8'h1F;
        p[nb * r - 1] = p[nb * r - 1] | 8'h80;
        for (int i = 0; i < nb; i++) begin
            blk = '0;
            for (int j = 0; j < r; j++) blk[j*8 +: 8] = p[i*r + j];
            exp.push_back(blk);
        end
    endfunction

    function automatic int first_diff(input logic [RM-1:0] x, input logic [RM-1:0] y);
        for (int k = 0; k < RM / 8; k++) if (x[k*8 +: 8] !== y[k*8 +: 8]) return k;
        return 0;
    endfunction

    // Sends one message as words; non-last keeps and later mode_in values are junk.
    task automatic drive_msg(input bit w32, input bit mode, input logic [7:0] msg[$], input bit extra_empty,
                             output int first_acc, output int last_acc, output bit to);
        int wb, len, nw, tot, k, waited;
        bit acc, last;
        logic [63:0] d;
        wb = w32 ? 4 : 8;
        len = msg.size();
        nw = len / wb + (((len % wb) != 0) ? 1 : 0);
        tot = nw + ((extra_empty || nw == 0) ? 1 : 0);
        to = 0; first_acc = -1; last_acc = -1;
        for (int w = 0; w < tot; w++) begin
            k = (w < nw) ? (((len - w*wb) < wb) ? (len - w*wb) : wb) : 0;
            d = {$urandom, $urandom};
            for (int b = 0; b < k; b++) d[b*8 +: 8] = msg[w*wb + b];
            last = (w == tot - 1);
            if (w32) begin
                in_valid_b = 1; in_data_b = d[31:0]; in_last_b = last;
                in_keep_b = last ? 3'(k) : 3'($urandom); mode_b = (w == 0) ? mode : 1'($urandom);
            end else begin
                in_valid_a = 1; in_data_a = d; in_last_a = last;
                in_keep_a = last ? 4'(k) : 4'($urandom); mode_a = (w == 0) ? mode : 1'($urandom);
            end
            acc = 0; waited = 0;
            while (!acc) begin
                acc = w32 ? in_ready_b : in_ready_a;
                @(posedge clk); #1;
                if (!acc && ++waited > 3000) begin
                    to = 1; in_valid_a = 0; in_valid_b = 0;
                    return;
                end
            end
            if (w == 0) first_acc = cyc;
            if (last) last_acc = cyc;
        end
        in_valid_a = 0; in_valid_b = 0; in_last_a = 0; in_last_b = 0;
    endtask

    // Collects blocks until one flagged last, holding each for 'hold' cycles.
    task automatic capture(input bit w32, input int hold, output logic [RM-1:0] blks[$], output bit lasts[$],
                           output bit modes[$], output int first_seen, output int hs_cyc,
                           output bit unstable, output bit to, output bit drop_bad);
        logic [RM-1:0] d;
        bit l, m, v;
        int waited;
        blks.delete(); lasts.delete(); modes.delete();
        first_seen = -1; hs_cyc = -1; unstable = 0; to = 0; drop_bad = 0;
        for (int n = 0; n < 8; n++) begin
            waited = 0;
            v = w32 ? blk_valid_b : blk_valid_a;
            while (!v) begin
                @(posedge clk); #1;
                v = w32 ? blk_valid_b : blk_valid_a;
                if (!v && ++waited > 3000) begin to = 1; return; end
            end
            d = w32 ? blk_data_b : blk_data_a;
            l = w32 ? blk_last_b : blk_last_a;
            m = w32 ? blk_mode_b : blk_mode_a;
            if (n == 0) first_seen = cyc;
            blks.push_back(d); lasts.push_back(l); modes.push_back(m);
            for (int h = 0; h <= hold; h++) begin
                if (w32 ? ({blk_data_b, blk_last_b, blk_mode_b, blk_valid_b, in_ready_b} !== {d, l, m, 2'b10})
                        : ({blk_data_a, blk_last_a, blk_mode_a, blk_valid_a, in_ready_a} !== {d, l, m, 2'b10}))
                    unstable = 1;
                if (h < hold) begin @(posedge clk); #1; end
            end
            if (w32) blk_ready_b = 1; else blk_ready_a = 1;
            @(posedge clk); #1;
            blk_ready_a = 0; blk_ready_b = 0;
            if (n == 0) hs_cyc = cyc;
            if ((w32 ? blk_valid_b : blk_valid_a) !== 1'b0) drop_bad = 1;
            if (l) return;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk); #1;
        total++; if ({in_ready_a, in_ready_b} !== 2'b00) begin bad++; $display("FAIL reset_in_ready got=%b req=00", {in_ready_a, in_ready_b}); end
        total++; if ({blk_valid_a, blk_valid_b} !== 2'b00) begin bad++; $display("FAIL reset_blk_valid got=%b req=00", {blk_valid_a, blk_valid_b}); end
        total++; if (blk_data_a !== '0 || blk_data_b !== '0) begin bad++; $display("FAIL reset_blk_data nonzero req=0"); end
        total++; if ({blk_last_a, blk_mode_a, blk_last_b, blk_mode_b} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b req=0000", {blk_last_a, blk_mode_a, blk_last_b, blk_mode_b}); end
        rst = 1;
        @(posedge clk); #1;
        total++; if ({in_ready_a, in_ready_b} !== 2'b11) begin bad++; $display("FAIL idle_in_ready got=%b req=11", {in_ready_a, in_ready_b}); end
        total++; if ({blk_valid_a, blk_valid_b} !== 2'b00) begin bad++; $display("FAIL idle_blk_valid got=%b req=00", {blk_valid_a, blk_valid_b}); end
        $display("reset: checked");
    endtask

    task automatic test_single_word;
        logic [7:0] msg[$];
        logic [RM-1:0] got[$];
        logic [RM-1:0] e;
        bit gl[$], gm[$], to1, to2, unst, drop;
        int fa, la, fs, hs;
        msg = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        e = '0; e[63:0] = 64'h0807060504030201; e[71:64] = 8'h1F; e[1343:1336] = 8'h80;
        fork
            drive_msg(0, 0, msg, 0, fa, la, to1);
            capture(0, 0, got, gl, gm, fs, hs, unst, to2, drop);
        join
        total++; if (to1 || to2 || got.size() != 1) begin bad++; $display("FAIL single_count got=%0d req=1 timeout=%b", got.size(), to1 | to2); end
        else begin
            total++; if (got[0] !== e) begin bad++; $display("FAIL single_data byte=%0d got=%h req=%h", first_diff(got[0], e), got[0][first_diff(got[0], e)*8 +: 8], e[first_diff(got[0], e)*8 +: 8]); end
            total++; if ({gl[0], gm[0]} !== 2'b10) begin bad++; $display("FAIL single_flags last/mode got=%b req=10", {gl[0], gm[0]}); end
            total++; if (fs !== la) begin bad++; $display("FAIL single_latency valid_cyc=%0d req=%0d", fs, la); end
            total++; if (drop) begin bad++; $display("FAIL single_valid_drop got=1 req=0"); end
        end
        $display("single word: %0d block(s)", got.size());
    endtask

    task automatic test_boundary;
        logic [7:0] msg[$];
        logic [RM-1:0] got[$], exp[$];
        bit gl[$], gm[$], to1, to2, unst, drop;
        int fa, la, fs, hs;
        repeat (168) msg.push_back(8'($urandom));
        model(0, msg, exp);
        fork
            drive_msg(0, 0, msg, 0, fa, la, to1);
            capture(0, 1, got, gl, gm, fs, hs, unst, to2, drop);
        join
        total++; if (to1 || to2 || got.size() != 2) begin bad++; $display("FAIL boundary_count got=%0d req=2", got.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL boundary_data blk=%0d byte=%0d got=%h req=%h", i, first_diff(got[i], exp[i]), got[i][first_diff(got[i], exp[i])*8 +: 8], exp[i][first_diff(got[i], exp[i])*8 +: 8]); end
            end
            total++; if ({gl[0], gl[1]} !== 2'b01) begin bad++; $display("FAIL boundary_last got=%b req=01", {gl[0], gl[1]}); end
        end
        $display("boundary: %0d block(s)", got.size());
    endtask

    task automatic test_shake256;
        logic [7:0] msg[$];
        logic [RM-1:0] got[$], exp[$];
        bit gl[$], gm[$], to1, to2, unst, drop;
        int fa, la, fs, hs;
        repeat (135) msg.push_back(8'($urandom));
        model(1, msg, exp);
        fork
            drive_msg(0, 1, msg, 0, fa, la, to1);
            capture(0, 0, got, gl, gm, fs, hs, unst, to2, drop);
        join
        total++; if (to1 || to2 || got.size() != 1) begin bad++; $display("FAIL s256_count got=%0d req=1", got.size()); end
        else begin
            total++; if (got[0][135*8 +: 8] !== 8'h9F) begin bad++; $display("FAIL s256_byte135 got=%h req=9f", got[0][135*8 +: 8]); end
            total++; if (got[0][RM-1:1088] !== '0) begin bad++; $display("FAIL s256_above_rate got=nonzero req=0"); end
            total++; if (got[0] !== exp[0]) begin bad++; $display("FAIL s256_data byte=%0d got=%h req=%h", first_diff(got[0], exp[0]), got[0][first_diff(got[0], exp[0])*8 +: 8], exp[0][first_diff(got[0], exp[0])*8 +: 8]); end
            total++; if ({gl[0], gm[0]} !== 2'b11) begin bad++; $display("FAIL s256_flags last/mode got=%b req=11", {gl[0], gm[0]}); end
        end
        $display("shake256 135 bytes: %0d block(s)", got.size());
    endtask

    task automatic test_empty32;
        logic [7:0] msg[$];
        logic [RM-1:0] got[$];
        logic [RM-1:0] e;
        bit gl[$], gm[$], to1, to2, unst, drop;
        int fa, la, fs, hs;
        e = '0; e[7:0] = 8'h1F; e[1343:1336] = 8'h80;
        fork
            drive_msg(1, 0, msg, 0, fa, la, to1);
            capture(1, 2, got, gl, gm, fs, hs, unst, to2, drop);
        join
        total++; if (to1 || to2 || got.size() != 1) begin bad++; $display("FAIL empty32_count got=%0d req=1", got.size()); end
        else begin
            total++; if (got[0] !== e) begin bad++; $display("FAIL empty32_data byte=%0d got=%h req=%h", first_diff(got[0], e), got[0][first_diff(got[0], e)*8 +: 8], e[first_diff(got[0], e)*8 +: 8]); end
            total++; if (gl[0] !== 1'b1) begin bad++; $display("FAIL empty32_last got=%b req=1", gl[0]); end
            total++; if (in_ready_b !== 1'b1) begin bad++; $display("FAIL empty32_ready_after got=%b req=1", in_ready_b); end
        end
        $display("empty w32: %0d block(s)", got.size());
    endtask

    task automatic test_backpressure;
        logic [7:0] m1[$], m2[$];
        logic [RM-1:0] g1[$], g2[$], e1[$], e2[$];
        bit l1[$], l2[$], d1[$], d2[$], ta1, ta2, tb1, tb2, u1, u2, dr1, dr2;
        int fa1, la1, fa2, la2, fs1, hs1, fs2, hs2;
        repeat (8) m1.push_back(8'($urandom));
        repeat (3) m2.push_back(8'($urandom));
        model(0, m1, e1);
        model(1, m2, e2);
        fork
            begin drive_msg(0, 0, m1, 0, fa1, la1, ta1); drive_msg(0, 1, m2, 0, fa2, la2, ta2); end
            begin capture(0, 5, g1, l1, d1, fs1, hs1, u1, tb1, dr1); capture(0, 0, g2, l2, d2, fs2, hs2, u2, tb2, dr2); end
        join
        total++; if (ta1 || ta2 || tb1 || tb2 || g1.size() != 1 || g2.size() != 1) begin bad++; $display("FAIL bp_count got=%0d,%0d req=1,1", g1.size(), g2.size()); end
        else begin
            total++; if (u1) begin bad++; $display("FAIL bp_stable got=changed req=stable"); end
            total++; if (fa2 <= hs1) begin bad++; $display("FAIL bp_accept_order msg2_acc=%0d req>%0d", fa2, hs1); end
            total++; if (g1[0] !== e1[0] || g2[0] !== e2[0]) begin bad++; $display("FAIL bp_data byte=%0d got=%h req=%h", first_diff(g1[0], e1[0]), g1[0][first_diff(g1[0], e1[0])*8 +: 8], e1[0][first_diff(g1[0], e1[0])*8 +: 8]); end
            total++; if ({d1[0], d2[0]} !== 2'b01) begin bad++; $display("FAIL bp_mode got=%b req=01", {d1[0], d2[0]}); end
        end
        $display("backpressure: msg2 accepted at cycle %0d, handshake at %0d", fa2, hs1);
    endtask

    task automatic test_reset_mid;
        logic [7:0] msg[$];
        logic [RM-1:0] got[$], exp[$];
        bit gl[$], gm[$], to1, to2, unst, drop, seen;
        int fa, la, fs, hs;
        for (int w = 0; w < 10; w++) begin
            in_valid_a = 1; in_data_a = {$urandom, $urandom}; in_last_a = 0; mode_a = 0;
            @(posedge clk); #1;
        end
        in_valid_a = 0;
        rst = 0; #1;
        total++; if (blk_data_a !== '0) begin bad++; $display("FAIL midreset_data got=nonzero req=0"); end
        total++; if ({in_ready_a, blk_valid_a, blk_last_a, blk_mode_a} !== 4'b0) begin bad++; $display("FAIL midreset_outputs got=%b req=0000", {in_ready_a, blk_valid_a, blk_last_a, blk_mode_a}); end
        @(posedge clk); #1;
        rst = 1;
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (blk_valid_a) seen = 1; end
        total++; if (seen) begin bad++; $display("FAIL midreset_no_block got=valid req=none"); end
        repeat (5) msg.push_back(8'($urandom));
        model(0, msg, exp);
        fork
            drive_msg(0, 0, msg, 0, fa, la, to1);
            capture(0, 0, got, gl, gm, fs, hs, unst, to2, drop);
        join
        total++; if (to1 || to2 || got.size() != 1 || got[0] !== exp[0]) begin bad++; $display("FAIL midreset_fresh_block count=%0d req=1 timeout=%b", got.size(), to1 | to2); end
        $display("reset mid-message: fresh block count %0d", got.size());
    endtask

    task automatic test_random;
        logic [7:0] msg[$];
        logic [RM-1:0] got[$], exp[$];
        bit gl[$], gm[$], to1, to2, unst, drop, w32, md, xe;
        int fa, la, fs, hs, len, hold;
        int bnd[6] = '{168, 136, 0, 167, 135, 272};
        for (int it = 0; it < 14; it++) begin
            w32 = 1'($urandom); md = 1'($urandom); xe = ($urandom_range(0, 3) == 0);
            len = (it < 6) ? bnd[it] : $urandom_range(0, 320);
            hold = $urandom_range(0, 2);
            if (xe) len = len - (len % (w32 ? 4 : 8));
            msg.delete();
            repeat (len) msg.push_back(8'($urandom));
            model(md, msg, exp);
            fork
                drive_msg(w32, md, msg, xe, fa, la, to1);
                capture(w32, hold, got, gl, gm, fs, hs, unst, to2, drop);
            join
            total++;
            if (to1 || to2 || got.size() != exp.size()) begin
                bad++; $display("FAIL rand_count it=%0d got=%0d req=%0d timeout=%b", it, got.size(), exp.size(), to1 | to2);
            end else begin
                for (int i = 0; i < exp.size(); i++) begin
                    total++;
                    if (got[i] !== exp[i] || gl[i] !== (i == exp.size() - 1) || gm[i] !== md) begin
                        bad++; $display("FAIL rand_block it=%0d blk=%0d byte=%0d got=%h req=%h last=%b mode=%b req_mode=%b", it, i, first_diff(got[i], exp[i]), got[i][first_diff(got[i], exp[i])*8 +: 8], exp[i][first_diff(got[i], exp[i])*8 +: 8], gl[i], gm[i], md);
                    end
                end
                total++; if (unst || drop) begin bad++; $display("FAIL rand_hold it=%0d unstable=%b valid_after_hs=%b req=0,0", it, unst, drop); end
            end
            $display("random it=%0d w32=%0d mode=%0d len=%0d extra_empty=%0d blocks=%0d", it, w32, md, len, xe, got.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_boundary();
        test_shake256();
        test_empty32();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shake_absorb_buffer.md
Name: shake_absorb_buffer

Overview:
- Parametrised successor to the SHAKE load stage: accepts a W-bit message word stream and assembles one rate-sized block at a time.
- Applies SHAKE domain padding (0x1F … 0x80) in hardware for both SHAKE128 and SHAKE256, selected per message.
- Hands each completed block to the permute stage through a valid/ready block interface, flagging the last block of the message.
- Supersedes the fixed-width load stage and its external set/clear latch handshake.

Parameters:
- W, 64, input word width in bits; allowed values 32 or 64.
- RATE_MAX, 1344, block register width in bits; equals the SHAKE128 rate.
- KW, $clog2(W/8)+1, width of in_keep (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- mode_in  in  1  0 = SHAKE128 (rate 1344 bits), 1 = SHAKE256 (rate 1088 bits); sampled with the first accepted word of a message.
- in_valid  in  1  word valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_data  in  W  message word, little-endian (byte 0 in bits [7:0]).
- in_last  in  1  final word of the message.
- in_keep  in  KW  number of valid bytes in the last word (0..W/8); ignored unless in_last.
- blk_valid  out  1  block available.
- blk_ready  in  1  permute stage takes the block when blk_valid && blk_ready.
- blk_data  out  RATE_MAX  block; word i sits at [i*W +: W]; bits at and above the active rate are 0.
- blk_last  out  1  block carries the padding end (0x80 byte).
- blk_mode  out  1  mode of the message this block belongs to.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, buffer cleared, state IDLE, word counter 0. In IDLE after reset release, in_ready=1.
- Words per block: NW = rate/W. SHAKE128: 21 (W=64) / 42 (W=32). SHAKE256: 17 / 34.
- States:
  - IDLE: first accepted word latches mode into blk_mode and goes to ABSORB, with the word processed as in ABSORB.
  - ABSORB: each accepted word is written at the word counter; the counter increments.
    - Non-last word fills the block (counter = NW-1) -> HOLD, blk_last=0.
    - Last word with free space (message byte position p < rate/8 after the data): bytes at and above keep are zeroed, byte p |= 0x1F, byte rate/8-1 |= 0x80 (0x9F if p is the final byte) -> HOLD, blk_last=1.
    - Last word ending exactly on the block boundary (full keep in word NW-1) -> HOLD with blk_last=0, then PAD.
  - PAD: buffer cleared; byte 0 = 0x1F, byte rate/8-1 = 0x80 -> HOLD, blk_last=1.
  - HOLD: blk_valid=1; in_ready=0. blk_data, blk_last and blk_mode stay stable until the handshake.
    - On handshake: buffer and counter cleared, blk_valid=0 next cycle.
    - Next state: PAD if pending, ABSORB if the message continues, IDLE if blk_last.
- Latency: blk_valid rises the cycle after the completing word is accepted. The PAD block appears the cycle after the preceding block's handshake.
- in_ready=1 only in IDLE and ABSORB. There is no combinational path from blk_ready to in_ready.
- Empty message: in_last=1, in_keep=0 in IDLE -> a single padding-only block (0x1F at byte 0, 0x80 at the top byte), blk_last=1.
- in_keep=0 on a last word mid-block: padding starts at that word's byte 0.
- mode_in is ignored except on a message's first word.
- Reset mid-message discards the partial block; no block is emitted.
- Buffer stores are byte-masked; accumulated bytes never wrap past the rate.

Decomposition:
- Package shake_pkg:
  - RATE_SHAKE128=1344, RATE_SHAKE256=1088.
  - PAD_DOMAIN=8'h1F, PAD_END=8'h80.
  - typedef enum for shake_mode_t.
  - typedef enum {IDLE, ABSORB, PAD, HOLD} absorb_state_t.
- One sub-module, shake_pad_word: combinational; takes a word, keep and pad flags, and returns the masked/padded word. Used for both the in-word and the top-byte padding.

Test Plan:
- W=64, SHAKE128, one word 0x0807060504030201, last, keep=8 -> one block: word0 = data, byte 8 = 0x1F, byte 167 = 0x80, all else 0, blk_last=1, blk_valid one cycle after acceptance.
- W=64, SHAKE128, 21 full words, last on the 21st -> block 1 holds all data with blk_last=0; block 2 is 0x1F at byte 0, 0x80 at byte 167, blk_last=1.
- W=64, SHAKE256, 17 words, last keep=7 (135 bytes) -> single block, byte 135 = 0x9F, bits 1088..1343 = 0, blk_mode=1.
- W=32, empty message (last, keep=0) -> one padding-only block of 42 words with blk_last=1; in_ready back to 1 after the handshake.
- Backpressure: hold blk_ready=0 for 5 cycles -> in_ready=0 and blk_data stable throughout; a second message's words are accepted only after the handshake.
- Assert rst=0 after 10 words of a SHAKE128 message -> outputs 0 immediately; a fresh 1-word message after release yields a correct single block with no stale data.
